// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory path.
//   mem_size_e     : access size encoding (funct3[1:0])
//   dmem_state_e   : responder FSM states
//   mem_lane_mask  : byte-lane enables for a size and a (naturally aligned) byte offset
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

  // Half accesses use lanes {offset[1],0} and {offset[1],1}; the caller has
  // already forced offset[0] to zero for halves.
  function automatic logic [3:0] mem_lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core LSU (master) and the memory responder (slave).
//   req_*  : request channel, valid/ready handshake, one request in flight
//   rsp_*  : response channel, valid/ready handshake
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data array.
//   size, offset   : access size and naturally aligned byte offset within the word
//   is_unsigned    : zero-extend loads when 1
//   wdata          : LSB-justified store data
//   rword          : word currently held at the target index
//   lane_wdata     : store data replicated onto its lanes
//   lane_be        : per-byte write enables
//   rdata          : extracted and extended load data
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_be,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    lane_be    = mem_lane_mask(size, offset);
    lane_wdata = wdata;
    shifted    = rword >> {offset, 3'b000};
    rdata      = shifted;
    case (size)
      SZ_BYTE: begin
        lane_wdata = {4{wdata[7:0]}};
        rdata      = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        lane_wdata = {2{wdata[15:0]}};
        rdata      = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle memory responder for the core's load/store port.
// One request at a time; WAIT_STATES extra cycles between accept and response.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; aborts any uncommitted access
//   bus    : dmem_responder_if.slave (request and response channels)
// Parameters: DEPTH_WORDS (power of 2), WAIT_STATES (0..15).
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise the low address bits are ignored (natural alignment).
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int AW      = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q;
  logic        we_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic        fire, commit;
  logic        c_we, c_uns, c_err, c_out_of_range;
  logic [31:0] c_addr, c_wdata;
  logic [1:0]  c_size, c_off;
  logic [AW-1:0] c_idx;
  logic [31:0] lane_wdata, ld_data, rword;
  logic [3:0]  lane_be;

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign fire   = bus.req_valid && bus.req_ready;
  assign commit = (NO_WAIT && fire) || (state_q == ST_WAIT && cnt_q == 4'd1);

  // Without wait states the access commits on the accept edge, so it must
  // see the live request rather than the latched copy.
  assign c_we    = NO_WAIT ? bus.req_we       : we_q;
  assign c_addr  = NO_WAIT ? bus.req_addr     : addr_q;
  assign c_size  = NO_WAIT ? bus.req_size     : size_q;
  assign c_uns   = NO_WAIT ? bus.req_unsigned : uns_q;
  assign c_wdata = NO_WAIT ? bus.req_wdata    : wdata_q;

  assign c_out_of_range = (c_addr >> (AW + 2)) != 32'd0;
  assign c_idx          = c_addr[AW+1:2];

  always_comb begin
    c_off = c_addr[1:0];
    c_err = c_out_of_range || (c_size == SZ_RSVD);
    case (c_size)
      SZ_HALF: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        c_err = c_err || c_addr[0];
`endif
        c_off[0] = 1'b0;
      end
      SZ_WORD: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        c_err = c_err || (c_addr[1:0] != 2'b00);
`endif
        c_off = 2'b00;
      end
      default: ;
    endcase
  end

  assign rword = mem[c_idx];

  dmem_lane_align u_align (
    .size        (c_size),
    .offset      (c_off),
    .is_unsigned (c_uns),
    .wdata       (c_wdata),
    .rword       (rword),
    .lane_wdata  (lane_wdata),
    .lane_be     (lane_be),
    .rdata       (ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fire) state_d = NO_WAIT ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd1) state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 2'b00;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_addr;
        size_q  <= bus.req_size;
        wdata_q <= bus.req_wdata;
        cnt_q   <= 4'(WAIT_STATES);
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        err_q   <= c_err;
        rdata_q <= (c_we || c_err) ? 32'd0 : ld_data;
      end
    end
  end

  // NOTE: the data array has no reset; its contents survive reset and only
  // the write enable is gated so a reset edge drops a pending store.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_we && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) mem[c_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

endmodule
